cim_psum_accumulator: RTL and testbench

Downstream stage of the 16-core CIM macro. It consumes the macro's 22-bit signed adder-tree result `Q` and accumulates NUM_PASS consecutive compute passes into one saturating partial sum, for input vectors longer than one macro pass. Completed sums go into a small output FIFO with valid/ready handshake. It also paces the upstream sequencer through `ISSUE_READY` and `START_READY`, so no result can ever be dropped.

---
 rtl/cim_psum_accumulator_if.sv | 30 +++
 rtl/cim_psum_accumulator.sv | 188 ++++++++++++++++++
 tb/tb_cim_psum_accumulator.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cim_psum_accumulator_if.sv
// Handshake bundle between the CIM sequencer/consumer and the partial-sum accumulator.
// Master drives job control, pass issue, macro result and output ready; slave answers.
interface cim_psum_accumulator_if #(
    parameter int unsigned Q_WIDTH        = 22,
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned PASS_CNT_WIDTH = 8
);
    logic                      START;
    logic                      START_READY;
    logic [PASS_CNT_WIDTH-1:0] NUM_PASS;
    logic                      ISSUE;
    logic                      ISSUE_READY;
    logic [Q_WIDTH-1:0]        Q;
    logic                      OUT_VALID;
    logic                      OUT_READY;
    logic [ACC_WIDTH-1:0]      OUT_DATA;
    logic                      OUT_SAT;
    logic                      BUSY;
    logic                      ERR;

    modport master (
        output START, NUM_PASS, ISSUE, Q, OUT_READY,
        input  START_READY, ISSUE_READY, OUT_VALID, OUT_DATA, OUT_SAT, BUSY, ERR
    );

    modport slave (
        input  START, NUM_PASS, ISSUE, Q, OUT_READY,
        output START_READY, ISSUE_READY, OUT_VALID, OUT_DATA, OUT_SAT, BUSY, ERR
    );
endinterface

// File: rtl/cim_psum_accumulator.sv
// Accumulates NUM_PASS consecutive CIM macro results into one saturating partial sum,
// pacing the sequencer so every result has a guaranteed slot in the output FIFO.
module cim_psum_accumulator #(
    parameter int unsigned Q_WIDTH        = 22,
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned PASS_CNT_WIDTH = 8,
    parameter int unsigned LATENCY        = 3,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input logic                    CLK,
    input logic                    NRST,
    cim_psum_accumulator_if.slave  bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = ACC_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic                      r_live;
    logic [PASS_CNT_WIDTH-1:0] r_num_pass;
    logic [PASS_CNT_WIDTH-1:0] r_issued_cnt;
    logic                      r_err;

    logic [LATENCY-1:0]        r_tag_valid;
    logic [LATENCY-1:0]        r_tag_first;
    logic [LATENCY-1:0]        r_tag_last;

    logic [ACC_WIDTH-1:0]      r_acc;
    logic                      r_sat;

    logic [ACC_WIDTH-1:0]      r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     r_fifo_sat;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;

    logic                      w_start_acc;
    logic                      w_start_job;
    logic                      w_issue_acc;
    logic                      w_issue_first;
    logic                      w_issue_last;
    logic                      w_ret_valid;
    logic                      w_ret_first;
    logic                      w_ret_last;
    logic                      w_push;
    logic                      w_pop;
    logic [SUM_W-1:0]          w_q_ext;
    logic [SUM_W-1:0]          w_acc_ext;
    logic [SUM_W-1:0]          w_sum;
    logic                      w_ovf;
    logic [ACC_WIDTH-1:0]      w_acc_next;
    logic                      w_sat_next;

    // Handshake qualifiers; all readies depend on registered state only.
    always_comb begin
        bus.START_READY = r_live && (r_state == StIdle) && (r_count < CNT_W'(FIFO_DEPTH));
        bus.ISSUE_READY = (r_state == StRun) && (r_issued_cnt < r_num_pass);
        bus.OUT_VALID   = (r_count != '0);
        bus.BUSY        = (r_state != StIdle);
        bus.ERR         = r_err;
        // Head is masked when empty so stale entries never leak onto the bus.
        bus.OUT_DATA    = bus.OUT_VALID ? r_fifo_data[r_rd_ptr] : '0;
        bus.OUT_SAT     = bus.OUT_VALID ? r_fifo_sat[r_rd_ptr] : 1'b0;

        w_start_acc   = bus.START && bus.START_READY;
        w_start_job   = w_start_acc && (bus.NUM_PASS != '0);
        w_issue_acc   = bus.ISSUE && bus.ISSUE_READY;
        w_issue_first = (r_issued_cnt == '0);
        w_issue_last  = (r_issued_cnt == (r_num_pass - PASS_CNT_WIDTH'(1)));

        w_ret_valid = r_tag_valid[LATENCY-1];
        w_ret_first = r_tag_first[LATENCY-1];
        w_ret_last  = r_tag_last[LATENCY-1];
        w_push      = w_ret_valid && w_ret_last;
        w_pop       = bus.OUT_VALID && bus.OUT_READY;
    end

    // Saturating accumulate in one extra bit, then clamp back to ACC_WIDTH.
    always_comb begin
        w_q_ext   = {{(SUM_W - Q_WIDTH){bus.Q[Q_WIDTH-1]}}, bus.Q};
        w_acc_ext = {r_acc[ACC_WIDTH-1], r_acc};
        w_sum     = w_ret_first ? w_q_ext : (w_acc_ext + w_q_ext);
        w_ovf     = (w_sum[SUM_W-1] != w_sum[SUM_W-2]);
        if (!w_ovf) begin
            w_acc_next = w_sum[ACC_WIDTH-1:0];
        end else if (w_sum[SUM_W-1]) begin
            w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        w_sat_next = (w_ret_first ? 1'b0 : r_sat) | w_ovf;
    end

    // Next-state logic for the job FSM.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start_job) w_state_next = StRun;
            StRun:   if (w_issue_acc && w_issue_last) w_state_next = StDrain;
            StDrain: if (w_push) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Job control: state, latched pass count, issue counter, zero-pass error pulse.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state      <= StIdle;
            r_live       <= 1'b0;
            r_num_pass   <= '0;
            r_issued_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            r_err   <= w_start_acc && (bus.NUM_PASS == '0);
            if (w_start_job) begin
                r_num_pass   <= bus.NUM_PASS;
                r_issued_cnt <= '0;
            end else if (w_issue_acc) begin
                r_issued_cnt <= r_issued_cnt + PASS_CNT_WIDTH'(1);
            end
        end
    end

    // Tag pipe: a tag leaves the last stage on the edge where its Q is sampled.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_tag_valid <= '0;
            r_tag_first <= '0;
            r_tag_last  <= '0;
        end else begin
            r_tag_valid[0] <= w_issue_acc;
            r_tag_first[0] <= w_issue_acc && w_issue_first;
            r_tag_last[0]  <= w_issue_acc && w_issue_last;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_first[i] <= r_tag_first[i-1];
                r_tag_last[i]  <= r_tag_last[i-1];
            end
        end
    end

    // Accumulator and sticky saturation flag, updated only on a retiring tag.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_ret_valid) begin
            r_acc <= w_acc_next;
            r_sat <= w_sat_next;
        end else if (w_start_job) begin
            r_sat <= 1'b0;
        end
    end

    // Output FIFO; START gating guarantees a free slot for every push.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_sat <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_acc_next;
                r_fifo_sat[r_wr_ptr]  <= w_sat_next;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cim_psum_accumulator.sv
// Directed bench for cim_psum_accumulator: expected results go into a scoreboard queue
// when each job is issued; a monitor pops and compares on every output handshake.
module tb_cim_psum_accumulator;

    localparam int unsigned QW  = 22;
    localparam int unsigned AW  = 24;
    localparam int unsigned PW  = 8;
    localparam int unsigned LAT = 3;
    localparam int unsigned FD  = 2;

    logic CLK;
    logic NRST;
    int   cyc;
    int   total;
    int   bad;

    logic [AW:0]   sb [$];      // {sat, data}
    logic [QW-1:0] q_at [int];  // Q value due at a given edge number

    cim_psum_accumulator_if #(.Q_WIDTH(QW), .ACC_WIDTH(AW), .PASS_CNT_WIDTH(PW)) bus ();

    cim_psum_accumulator #(
        .Q_WIDTH(QW), .ACC_WIDTH(AW), .PASS_CNT_WIDTH(PW), .LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .CLK  (CLK),
        .NRST (NRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Present the scheduled Q for the upcoming edge; junk elsewhere.
    always @(posedge CLK) begin
        #2;
        if (q_at.exists(cyc + 1)) bus.Q = q_at[cyc + 1];
        else bus.Q = QW'(999);
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare every accepted output against the scoreboard head.
    always @(negedge CLK) begin
        if (NRST && bus.OUT_VALID && bus.OUT_READY) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got 0x%0h expected no output", bus.OUT_DATA);
            end else begin
                logic [AW:0] e;
                e = sb.pop_front();
                check("out_data", 32'(bus.OUT_DATA), 32'(e[AW-1:0]));
                check("out_sat", 32'(bus.OUT_SAT), 32'(e[AW]));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input logic [PW-1:0] np);
        check("start_ready_before_start", 32'(bus.START_READY), 32'd1);
        bus.START    = 1'b1;
        bus.NUM_PASS = np;
        tick();
        bus.START = 1'b0;
    endtask

    // Accepted on the coming edge cyc+1, so its Q is due LAT edges later.
    task automatic issue_pass(input logic [QW-1:0] qv);
        check("issue_ready", 32'(bus.ISSUE_READY), 32'd1);
        q_at[cyc + 1 + LAT] = qv;
        bus.ISSUE = 1'b1;
        tick();
        bus.ISSUE = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_ready"}, 32'(bus.START_READY), 32'd0);
        check({tag, "_issue_ready"}, 32'(bus.ISSUE_READY), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'd0);
        check({tag, "_out_data"}, 32'(bus.OUT_DATA), 32'd0);
        check({tag, "_out_sat"}, 32'(bus.OUT_SAT), 32'd0);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_err"}, 32'(bus.ERR), 32'd0);
    endtask

    initial begin
        int wait_cnt;
        cyc = 0;
        total = 0;
        bad = 0;
        NRST = 1'b0;
        bus.START = 1'b0;
        bus.NUM_PASS = '0;
        bus.ISSUE = 1'b0;
        bus.OUT_READY = 1'b1;
        bus.Q = QW'(999);

        // Reset values
        tick();
        tick();
        check_reset_outputs("reset");
        NRST = 1'b1;
        tick();
        tick();
        check("start_ready_after_reset", 32'(bus.START_READY), 32'd1);

        // Basic job: 100 - 30 + 7 + 1 = 78
        sb.push_back({1'b0, AW'(78)});
        start_job(8'd4);
        issue_pass(QW'(100));
        issue_pass(-QW'(30));
        issue_pass(QW'(7));
        issue_pass(QW'(1));
        check("basic_valid_t0", 32'(bus.OUT_VALID), 32'd0);
        check("basic_issue_ready_drain", 32'(bus.ISSUE_READY), 32'd0);
        tick();
        check("basic_valid_t1", 32'(bus.OUT_VALID), 32'd0);
        tick();
        check("basic_valid_t2", 32'(bus.OUT_VALID), 32'd0);
        check("basic_busy_t2", 32'(bus.BUSY), 32'd1);
        tick();
        check("basic_valid_t3", 32'(bus.OUT_VALID), 32'd1);
        check("basic_busy_t3", 32'(bus.BUSY), 32'd0);
        tick();

        // Gaps, early/late ignored issues, START during final retire: 50 + 60 - 200 = -90
        bus.ISSUE = 1'b1;
        check("early_issue_ready", 32'(bus.ISSUE_READY), 32'd0);
        tick();
        bus.ISSUE = 1'b0;
        sb.push_back({1'b0, AW'(-90)});
        start_job(8'd3);
        issue_pass(QW'(50));
        tick();
        tick();
        issue_pass(QW'(60));
        tick();
        tick();
        issue_pass(-QW'(200));
        bus.ISSUE = 1'b1;
        check("late_issue_ready", 32'(bus.ISSUE_READY), 32'd0);
        tick();
        bus.ISSUE = 1'b0;
        tick();
        bus.START = 1'b1;
        bus.NUM_PASS = 8'd1;
        check("start_ready_in_drain", 32'(bus.START_READY), 32'd0);
        tick();
        bus.START = 1'b0;
        check("busy_after_retire", 32'(bus.BUSY), 32'd0);
        tick();
        check("drain_start_ignored", 32'(bus.BUSY), 32'd0);
        tick();

        // Saturation: 5 x 0x1FFFFF exceeds the 24-bit maximum
        sb.push_back({1'b1, AW'(24'h7FFFFF)});
        start_job(8'd5);
        for (int i = 0; i < 5; i++) issue_pass(QW'(22'h1FFFFF));
        repeat (LAT + 1) tick();
        // Sat flag clears on the next job
        sb.push_back({1'b0, AW'(5)});
        start_job(8'd1);
        issue_pass(QW'(5));
        repeat (LAT + 1) tick();
        // Negative clamp: 5 x -2^21 = -10485760 -> -8388608
        sb.push_back({1'b1, AW'(24'h800000)});
        start_job(8'd5);
        for (int i = 0; i < 5; i++) issue_pass(QW'(22'h200000));
        repeat (LAT + 1) tick();
        // Sticky: clamp at pass 5 to 0x7FFFFF, then -0x200000 -> 0x5FFFFF, sat stays set
        sb.push_back({1'b1, AW'(24'h5FFFFF)});
        start_job(8'd6);
        for (int i = 0; i < 5; i++) issue_pass(QW'(22'h1FFFFF));
        issue_pass(QW'(22'h200000));
        repeat (LAT + 1) tick();

        // Backpressure: two results held, START blocked until a pop
        bus.OUT_READY = 1'b0;
        sb.push_back({1'b0, AW'(10)});
        start_job(8'd1);
        issue_pass(QW'(10));
        repeat (LAT + 1) tick();
        sb.push_back({1'b0, AW'(-20)});
        start_job(8'd2);
        issue_pass(-QW'(5));
        issue_pass(-QW'(15));
        repeat (LAT + 1) tick();
        check("bp_start_ready_full", 32'(bus.START_READY), 32'd0);
        check("bp_head_hold0", 32'(bus.OUT_DATA), 32'(AW'(10)));
        tick();
        check("bp_head_hold1", 32'(bus.OUT_DATA), 32'(AW'(10)));
        check("bp_valid_hold", 32'(bus.OUT_VALID), 32'd1);
        bus.OUT_READY = 1'b1;
        tick();
        check("bp_start_ready_after_pop", 32'(bus.START_READY), 32'd1);
        tick();
        tick();

        // Zero-pass job
        start_job(8'd0);
        check("zero_err_pulse", 32'(bus.ERR), 32'd1);
        check("zero_busy", 32'(bus.BUSY), 32'd0);
        tick();
        check("zero_err_clear", 32'(bus.ERR), 32'd0);

        // Reset mid-job after 2 of 4 issues
        start_job(8'd4);
        issue_pass(QW'(1000));
        issue_pass(QW'(2000));
        NRST = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        tick();
        tick();
        NRST = 1'b1;
        q_at.delete();
        tick();
        tick();
        sb.push_back({1'b0, AW'(-7)});
        start_job(8'd1);
        issue_pass(-QW'(7));
        repeat (LAT + 1) tick();

        // Every expected result must have come out
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
